// File: rtl/lbfgs_load_ctrl_if.sv
// Host/core bus of the L-BFGS load controller: job control, load stream,
// core write port, result select and result drain stream.
interface lbfgs_load_ctrl_if #(
    parameter int DATA_WIDTH = 64
);
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  timeout_err;

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] in_data;

    logic                  wr_id;
    logic                  wr_coef;
    logic                  wr_idm;
    logic                  wr_impos;
    logic [9:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data0;
    logic [DATA_WIDTH-1:0] wr_data1;

    logic                  core_rst;
    logic                  core_valid;
    logic [5:0]            res_idx;
    logic [DATA_WIDTH-1:0] res_data;

    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;

    modport master (
        output start, in_valid, in_data, core_valid, res_data, out_ready,
        input  busy, done, timeout_err, in_ready,
               wr_id, wr_coef, wr_idm, wr_impos, wr_addr, wr_data0, wr_data1,
               core_rst, res_idx, out_valid, out_data
    );

    modport slave (
        input  start, in_valid, in_data, core_valid, res_data, out_ready,
        output busy, done, timeout_err, in_ready,
               wr_id, wr_coef, wr_idm, wr_impos, wr_addr, wr_data0, wr_data1,
               core_rst, res_idx, out_valid, out_data
    );
endinterface

// File: rtl/lbfgs_load_ctrl.sv
// Sequences one L-BFGS job: streams operands into the solver core, runs it
// under a cycle watchdog, then drains the result words to the host.
module lbfgs_load_ctrl #(
    parameter int DATA_WIDTH   = 64,
    parameter int NUM_ELEMENTS = 50,
    parameter int NUM_COEF     = 8,
    parameter int NUM_IDM      = 150,
    parameter int NUM_IMPOS    = 68,
    parameter int NUM_RESULTS  = 52,
    parameter int TIMEOUT      = 1048576
) (
    input logic              clk,
    input logic              rst_LBFGS,
    lbfgs_load_ctrl_if.slave bus
);
    localparam int MAX_A = (NUM_ELEMENTS > NUM_COEF) ? NUM_ELEMENTS : NUM_COEF;
    localparam int MAX_B = (NUM_IDM > NUM_IMPOS) ? NUM_IDM : NUM_IMPOS;
    localparam int MAX_N = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CW    = $clog2(MAX_N + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] LAST_ID    = CW'(NUM_ELEMENTS - 1);
    localparam logic [CW-1:0] LAST_COEF  = CW'(NUM_COEF - 1);
    localparam logic [CW-1:0] LAST_IDM   = CW'(NUM_IDM - 1);
    localparam logic [CW-1:0] LAST_IMPOS = CW'(NUM_IMPOS - 1);
    localparam logic [TW-1:0] LAST_RUN   = TW'(TIMEOUT - 1);
    localparam logic [5:0]    LAST_RES   = 6'(NUM_RESULTS - 1);

    typedef enum logic [2:0] {
        IDLE, LOAD_ID, LOAD_COEF, LOAD_IDM, LOAD_IMPOS, RUN, DRAIN, ERR
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  half_q, half_d;
    logic [DATA_WIDTH-1:0] even_q, even_d;
    logic [TW-1:0]         run_q, run_d;
    logic [5:0]            res_idx_q, res_idx_d;
    logic                  done_q, done_d;
    logic                  tmo_q, tmo_d;
    logic                  wr_id_q, wr_id_d, wr_coef_q, wr_coef_d;
    logic                  wr_idm_q, wr_idm_d, wr_impos_q, wr_impos_d;
    logic [9:0]            wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data0_q, wr_data0_d, wr_data1_q, wr_data1_d;

    logic                  loading, accept;
    logic [CW-1:0]         phase_last;
    state_t                phase_next;

    assign loading = (state_q == LOAD_ID) || (state_q == LOAD_COEF) ||
                     (state_q == LOAD_IDM) || (state_q == LOAD_IMPOS);
    assign accept  = loading && bus.in_valid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        half_d     = half_q;
        even_d     = even_q;
        run_d      = run_q;
        res_idx_d  = res_idx_q;
        done_d     = 1'b0;
        tmo_d      = tmo_q;
        wr_id_d    = 1'b0;
        wr_coef_d  = 1'b0;
        wr_idm_d   = 1'b0;
        wr_impos_d = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data0_d = wr_data0_q;
        wr_data1_d = wr_data1_q;
        phase_last = LAST_IDM;
        phase_next = LOAD_IMPOS;
        if (state_q == LOAD_ID) begin
            phase_last = LAST_ID;
            phase_next = LOAD_COEF;
        end else if (state_q == LOAD_COEF) begin
            phase_last = LAST_COEF;
            phase_next = LOAD_IDM;
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD_ID;
                    cnt_d   = '0;
                    half_d  = 1'b0;
                end
            end
            LOAD_ID, LOAD_COEF, LOAD_IDM: begin
                if (accept) begin
                    wr_id_d    = (state_q == LOAD_ID);
                    wr_coef_d  = (state_q == LOAD_COEF);
                    wr_idm_d   = (state_q == LOAD_IDM);
                    wr_addr_d  = 10'(cnt_q);
                    wr_data0_d = bus.in_data;
                    if (cnt_q == phase_last) begin
                        state_d = phase_next;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            LOAD_IMPOS: begin
                // cnt counts pairs; half marks that the even word is held
                if (accept && !half_q) begin
                    even_d = bus.in_data;
                    half_d = 1'b1;
                end else if (accept) begin
                    wr_impos_d = 1'b1;
                    wr_addr_d  = 10'(cnt_q);
                    wr_data0_d = even_q;
                    wr_data1_d = bus.in_data;
                    half_d     = 1'b0;
                    if (cnt_q == LAST_IMPOS) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        run_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            RUN: begin
                if (bus.core_valid) begin
                    state_d   = DRAIN;
                    res_idx_d = '0;
                end else if (run_q == LAST_RUN) begin
                    state_d = ERR;
                    tmo_d   = 1'b1;
                end else begin
                    run_d = run_q + TW'(1);
                end
            end
            DRAIN: begin
                if (bus.out_ready) begin
                    if (res_idx_q == LAST_RES) begin
                        state_d   = IDLE;
                        res_idx_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        res_idx_d = res_idx_q + 6'd1;
                    end
                end
            end
            ERR: begin
                state_d = ERR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_LBFGS) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            half_q     <= 1'b0;
            even_q     <= '0;
            run_q      <= '0;
            res_idx_q  <= '0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            wr_id_q    <= 1'b0;
            wr_coef_q  <= 1'b0;
            wr_idm_q   <= 1'b0;
            wr_impos_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data0_q <= '0;
            wr_data1_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            half_q     <= half_d;
            even_q     <= even_d;
            run_q      <= run_d;
            res_idx_q  <= res_idx_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            wr_id_q    <= wr_id_d;
            wr_coef_q  <= wr_coef_d;
            wr_idm_q   <= wr_idm_d;
            wr_impos_q <= wr_impos_d;
            wr_addr_q  <= wr_addr_d;
            wr_data0_q <= wr_data0_d;
            wr_data1_q <= wr_data1_d;
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = done_q;
    assign bus.timeout_err = tmo_q;
    assign bus.in_ready    = loading;
    assign bus.wr_id       = wr_id_q;
    assign bus.wr_coef     = wr_coef_q;
    assign bus.wr_idm      = wr_idm_q;
    assign bus.wr_impos    = wr_impos_q;
    assign bus.wr_addr     = wr_addr_q;
    assign bus.wr_data0    = wr_data0_q;
    assign bus.wr_data1    = wr_data1_q;
    assign bus.core_rst    = (state_q != RUN) && (state_q != DRAIN);
    assign bus.res_idx     = res_idx_q;
    assign bus.out_valid   = (state_q == DRAIN);
    assign bus.out_data    = bus.res_data;
endmodule

// File: tb/tb_lbfgs_load_ctrl.sv
// Directed bench for lbfgs_load_ctrl: full job, backpressure with stray
// inputs, RUN timeout, and reset in the middle of a load.
module tb_lbfgs_load_ctrl;
    localparam int DW      = 64;
    localparam int N_WORDS = 50 + 8 + 150 + 136;
    localparam int N_EV    = 50 + 8 + 150 + 68;

    typedef struct packed {
        logic [2:0]    kind;
        logic [9:0]    addr;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned multi_cnt = 0;
    ev_t         evq[$];

    lbfgs_load_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    lbfgs_load_ctrl #(
        .DATA_WIDTH(DW),
        .TIMEOUT   (16)
    ) dut (
        .clk      (clk),
        .rst_LBFGS(rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    // Solver result memory model: value depends only on the selected index
    function automatic logic [DW-1:0] res_model(input logic [5:0] idx);
        return {16'h5EED, 26'd0, idx, 10'd0, idx};
    endfunction

    assign bus.res_data = res_model(bus.res_idx);

    function automatic logic [DW-1:0] word(input int j);
        if (j < 50)  return 64'h1100_0000_0000_0000 + 64'(j);
        if (j < 58)  return 64'h2200_0000_0000_0000 + 64'(j - 50);
        if (j < 208) return 64'h3300_0000_0000_0000 + 64'(j - 58);
        if (((j - 208) % 2) == 0) return 64'hAA00_0000_0000_0000 + 64'((j - 208) / 2);
        return 64'hBB00_0000_0000_0000 + 64'((j - 208) / 2);
    endfunction

    function automatic ev_t exp_ev(input int e);
        ev_t v;
        v.d1 = '0;
        if (e < 50) begin
            v.kind = 3'd1; v.addr = 10'(e); v.d0 = word(e);
        end else if (e < 58) begin
            v.kind = 3'd2; v.addr = 10'(e - 50); v.d0 = word(e);
        end else if (e < 208) begin
            v.kind = 3'd3; v.addr = 10'(e - 58); v.d0 = word(e);
        end else begin
            v.kind = 3'd4; v.addr = 10'(e - 208);
            v.d0 = word(208 + 2 * (e - 208));
            v.d1 = word(209 + 2 * (e - 208));
        end
        return v;
    endfunction

    function automatic logic [25:0] obs_rst();
        return {bus.busy, bus.done, bus.timeout_err, bus.in_ready,
                bus.wr_id, bus.wr_coef, bus.wr_idm, bus.wr_impos,
                bus.core_rst, bus.out_valid, bus.res_idx, bus.wr_addr};
    endfunction

    localparam logic [25:0] RST_VEC = {10'b00_0000_0010, 6'd0, 10'd0};

    // Write-port monitor: one record per strobe-high cycle
    initial begin
        forever begin
            @(negedge clk);
            if ((int'(bus.wr_id) + int'(bus.wr_coef) + int'(bus.wr_idm) + int'(bus.wr_impos)) > 1)
                multi_cnt++;
            if (bus.wr_id)    evq.push_back({3'd1, bus.wr_addr, bus.wr_data0, {DW{1'b0}}});
            if (bus.wr_coef)  evq.push_back({3'd2, bus.wr_addr, bus.wr_data0, {DW{1'b0}}});
            if (bus.wr_idm)   evq.push_back({3'd3, bus.wr_addr, bus.wr_data0, {DW{1'b0}}});
            if (bus.wr_impos) evq.push_back({3'd4, bus.wr_addr, bus.wr_data0, bus.wr_data1});
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic load_all(input bit gaps, input bit stray_cv);
        int unsigned w;
        evq.delete();
        multi_cnt = 0;
        for (int j = 0; j < N_WORDS; j++) begin
            bus.in_valid   = 1'b1;
            bus.in_data    = word(j);
            bus.core_valid = stray_cv && (j >= 50) && (j < 58);
            w = 0;
            while (!bus.in_ready && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            n_cmp++;
            if ({bus.in_ready, bus.core_rst} !== 2'b11) begin
                n_err++;
                $display("FAIL load_ready word %0d: in_ready,core_rst got %b want 11", j,
                         {bus.in_ready, bus.core_rst});
            end
            @(posedge clk); #1;
            if (gaps) begin
                bus.in_valid = 1'b0;
                bus.in_data  = '1;
                @(posedge clk); #1;
            end
        end
        bus.in_valid   = 1'b0;
        bus.core_valid = 1'b0;
    endtask

    task automatic drain(input int hold_at, input bit stray_start);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 52; i++) begin
            n_cmp++;
            if ({bus.out_valid, bus.res_idx, bus.out_data} !== {1'b1, 6'(i), res_model(6'(i))}) begin
                n_err++;
                $display("FAIL drain_beat %0d: valid/idx/data got %b/%0d/%h want 1/%0d/%h", i,
                         bus.out_valid, bus.res_idx, bus.out_data, i, res_model(6'(i)));
            end
            if (i == hold_at) begin
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    n_cmp++;
                    if ({bus.out_valid, bus.res_idx, bus.out_data} !== {1'b1, 6'(i), res_model(6'(i))}) begin
                        n_err++;
                        $display("FAIL drain_hold: valid/idx/data got %b/%0d/%h want 1/%0d/%h",
                                 bus.out_valid, bus.res_idx, bus.out_data, i, res_model(6'(i)));
                    end
                end
                bus.out_ready = 1'b1;
            end
            bus.start = stray_start && (i == 20);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        n_cmp++;
        if ({bus.done, bus.busy, bus.out_valid, bus.core_rst} !== 4'b1001) begin
            n_err++;
            $display("FAIL done_pulse: done,busy,out_valid,core_rst got %b want 1001",
                     {bus.done, bus.busy, bus.out_valid, bus.core_rst});
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.done, bus.busy} !== 2'b00) begin
            n_err++;
            $display("FAIL done_single: done,busy got %b want 00", {bus.done, bus.busy});
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (obs_rst() !== RST_VEC) begin
            n_err++;
            $display("FAIL reset_state: got %b want %b", obs_rst(), RST_VEC);
        end
        n_cmp++;
        if ({bus.wr_data0, bus.wr_data1} !== 128'd0) begin
            n_err++;
            $display("FAIL reset_data: got %h %h want 0 0", bus.wr_data0, bus.wr_data1);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_full_job();
        pulse_start();
        n_cmp++;
        if ({bus.busy, bus.in_ready, bus.core_rst} !== 3'b111) begin
            n_err++;
            $display("FAIL job_start: busy,in_ready,core_rst got %b want 111",
                     {bus.busy, bus.in_ready, bus.core_rst});
        end
        load_all(1'b0, 1'b0);
        n_cmp++;
        if ({bus.core_rst, bus.busy, bus.in_ready, bus.out_valid} !== 4'b0100) begin
            n_err++;
            $display("FAIL run_entry: core_rst,busy,in_ready,out_valid got %b want 0100",
                     {bus.core_rst, bus.busy, bus.in_ready, bus.out_valid});
        end
        repeat (10) begin
            @(posedge clk); #1;
        end
        bus.core_valid = 1'b1;
        @(posedge clk); #1;
        bus.core_valid = 1'b0;
        drain(-1, 1'b0);
        n_cmp++;
        if (evq.size() != N_EV || multi_cnt != 0) begin
            n_err++;
            $display("FAIL full_write_count: events %0d overlaps %0d want %0d 0",
                     evq.size(), multi_cnt, N_EV);
        end
        for (int e = 0; e < N_EV && e < evq.size(); e++) begin
            n_cmp++;
            if (evq[e] !== exp_ev(e)) begin
                n_err++;
                $display("FAIL full_write %0d: got %h want %h", e, evq[e], exp_ev(e));
            end
        end
    endtask

    task automatic test_back_to_back();
        pulse_start();
        load_all(1'b1, 1'b1);
        n_cmp++;
        if ({bus.core_rst, bus.busy, bus.out_valid} !== 3'b010) begin
            n_err++;
            $display("FAIL bp_run: core_rst,busy,out_valid got %b want 010",
                     {bus.core_rst, bus.busy, bus.out_valid});
        end
        bus.core_valid = 1'b1;
        @(posedge clk); #1;
        bus.core_valid = 1'b0;
        drain(7, 1'b1);
        n_cmp++;
        if (evq.size() != N_EV || multi_cnt != 0) begin
            n_err++;
            $display("FAIL bp_write_count: events %0d overlaps %0d want %0d 0",
                     evq.size(), multi_cnt, N_EV);
        end
        for (int e = 0; e < N_EV && e < evq.size(); e++) begin
            n_cmp++;
            if (evq[e] !== exp_ev(e)) begin
                n_err++;
                $display("FAIL bp_write %0d: got %h want %h", e, evq[e], exp_ev(e));
            end
        end
    endtask

    task automatic test_timeout();
        pulse_start();
        load_all(1'b0, 1'b0);
        for (int k = 1; k < 16; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({bus.timeout_err, bus.core_rst, bus.busy} !== 3'b001) begin
                n_err++;
                $display("FAIL tmo_run cycle %0d: timeout_err,core_rst,busy got %b want 001",
                         k, {bus.timeout_err, bus.core_rst, bus.busy});
            end
        end
        @(posedge clk); #1;
        n_cmp++;
        if ({bus.timeout_err, bus.core_rst, bus.busy, bus.in_ready} !== 4'b1110) begin
            n_err++;
            $display("FAIL tmo_err: timeout_err,core_rst,busy,in_ready got %b want 1110",
                     {bus.timeout_err, bus.core_rst, bus.busy, bus.in_ready});
        end
        pulse_start();
        repeat (3) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({bus.timeout_err, bus.core_rst, bus.busy, bus.in_ready, bus.out_valid} !== 5'b11100 ||
                evq.size() != N_EV) begin
                n_err++;
                $display("FAIL tmo_sticky: flags got %b want 11100, events %0d want %0d",
                         {bus.timeout_err, bus.core_rst, bus.busy, bus.in_ready, bus.out_valid},
                         evq.size(), N_EV);
            end
        end
        rst = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (obs_rst() !== RST_VEC || {bus.wr_data0, bus.wr_data1} !== 128'd0) begin
            n_err++;
            $display("FAIL tmo_reset: got %b %h %h want %b 0 0",
                     obs_rst(), bus.wr_data0, bus.wr_data1, RST_VEC);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        pulse_start();
        for (int j = 0; j < 98; j++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = word(j);
            @(posedge clk); #1;
        end
        n_cmp++;
        if ({bus.wr_idm, bus.wr_addr, bus.wr_data0} !== {1'b1, 10'd39, word(97)}) begin
            n_err++;
            $display("FAIL mid_before: idm/addr/data got %b/%0d/%h want 1/39/%h",
                     bus.wr_idm, bus.wr_addr, bus.wr_data0, word(97));
        end
        bus.in_data = word(98);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++;
        if (obs_rst() !== RST_VEC) begin
            n_err++;
            $display("FAIL mid_reset_state: got %b want %b", obs_rst(), RST_VEC);
        end
        n_cmp++;
        if ({bus.wr_data0, bus.wr_data1} !== 128'd0) begin
            n_err++;
            $display("FAIL mid_reset_data: got %h %h want 0 0", bus.wr_data0, bus.wr_data1);
        end
        @(posedge clk); #1;
        pulse_start();
        bus.in_valid = 1'b1;
        bus.in_data  = 64'hFEED_FACE_0000_0001;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        n_cmp++;
        if ({bus.wr_id, bus.wr_coef, bus.wr_idm, bus.wr_impos, bus.wr_addr, bus.wr_data0} !==
            {4'b1000, 10'd0, 64'hFEED_FACE_0000_0001}) begin
            n_err++;
            $display("FAIL mid_restart: strobes/addr/data got %b/%0d/%h want 1000/0/feedface00000001",
                     {bus.wr_id, bus.wr_coef, bus.wr_idm, bus.wr_impos}, bus.wr_addr, bus.wr_data0);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.core_valid = 1'b0;
        bus.out_ready  = 1'b0;
        test_reset();
        test_full_job();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
        $fatal(1, "watchdog expired");
    end
endmodule
